ram256_arbiter: RTL
===================

# ram256_arbiter

Arbiter and sequencer for the single-port 256-entry cache data RAM. It shares the RAM between the CPU-side read port and the SPI line-fill write port. It drives the RAM control pins, tracks the one-cycle read latency, returns read data with a valid strobe, and bounds read starvation during long line fills. It sits between the cache lookup logic and the RAM macro.

## Interface
- WSIZE, 2: bytes per RAM word; data width is WSIZE*8.
- STARVE_MAX, 4: maximum consecutive cycles a pending read may be denied; range 1..15.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- rd_req  in  1  read request; held until rd_gnt.
- rd_addr  in  8  read word address.
- rd_gnt  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  read data valid; one-cycle pulse per granted read.
- rd_data  out  WSIZE*8  read data.
- wr_req  in  1  write request; held until wr_gnt.
- wr_addr  in  8  write word address.
- wr_data  in  WSIZE*8  write data.
- wr_be  in  WSIZE  byte enables; all-zero is illegal when wr_req=1.
- wr_gnt  out  1  write accepted this cycle (combinational).
- ram_en  out  1  to RAM EN0.
- ram_we  out  WSIZE  to RAM WE0.
- ram_addr  out  8  to RAM A0.
- ram_din  out  WSIZE*8  to RAM Di0.
- ram_dout  in  WSIZE*8  from RAM Do0; valid the cycle after an enabled access.

## Operation
- At most one grant per cycle. rd_gnt and wr_gnt are never both 1.
- When a request is granted, the RAM pins are driven in that cycle:
  - ram_en=1.
  - ram_addr is the granted address.
  - Write grant: ram_we=wr_be and ram_din=wr_data.
  - Read grant: ram_we=0.
- No grant: ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- Default priority is fixed with write first. A line fill must not stall the SPI stream.
- Starvation counter (4 bits):
  - Increments each cycle rd_req=1 and rd_gnt=0.
  - Clears on rd_gnt or when rd_req=0.
  - When it equals STARVE_MAX, the read wins the next contention cycle regardless of priority.
- rd_valid is registered. It is 1 in the cycle after rd_gnt and 0 otherwise.
- rd_data:
  - Equals ram_dout while rd_valid=1.
  - Otherwise a hold register returns the last read word, loaded when rd_valid=1.
  - Write grants never disturb rd_data.
- Read-after-write to the same address in the next cycle returns the new data. This follows from the single-port RAM and needs no bypass.
- Back-to-back read grants are legal, giving one rd_valid per cycle.

## Timing
- Read latency is 1 cycle: grant in cycle N, rd_valid and data in cycle N+1.
- Write completes at the rising edge ending the grant cycle.
- Reset values:
  - rd_valid=0, rd_data=0.
  - Starvation counter=0.
  - RR last-grant bit=write.
  - Grants and ram_* are 0 while RST=1.
- Reset in the cycle after a read grant: rd_valid stays 0 and that read is dropped. The requester must re-request.
- Requests are ignored while RST=1. Arbitration resumes the first cycle after RST falls.
- Dropping a request before its grant is legal and has no side effect except clearing the counter for reads.

## Configuration
- RAM_ARB_RR_EN defined:
  - Contention is resolved round-robin, and the winner is the port not granted at the most recent contention.
  - The starvation counter and STARVE_MAX are still implemented but never trigger.
- RAM_ARB_RR_EN undefined: fixed write-first priority with the starvation override, as described above.

## Test plan
- Single read: write 0xA5A5 to address 0x10, then rd_req addr 0x10. Expect rd_gnt in cycle N, rd_valid=1 and rd_data=0xA5A5 in N+1, and rd_data still 0xA5A5 at N+3.
- Byte enable: with address 0x20 initialised to 0x1234, write wr_data=0xFFFF, wr_be=2'b01. A subsequent read returns 0x12FF.
- Starvation (macro undefined, STARVE_MAX=4): hold wr_req and rd_req continuously. Expect 4 wr_gnt, then 1 rd_gnt, repeating. A read is never denied more than 4 consecutive cycles.
- Round-robin (RAM_ARB_RR_EN): hold both requests continuously. Grants alternate; the first is rd_gnt after reset.
- Reset mid-read: assert RST in the cycle after rd_gnt. Expect rd_valid=0, rd_data=0, and no grant until the cycle after RST deasserts.

Source files
------------

// File: rtl/ram256_arbiter_if.sv
// Request, response and RAM-pin bundle for ram256_arbiter.
// slave is the arbiter side; master is the cache/SPI/RAM side.
interface ram256_arbiter_if #(
    parameter int WSIZE = 2
);
    logic                 rd_req;
    logic [7:0]           rd_addr;
    logic                 rd_gnt;
    logic                 rd_valid;
    logic [WSIZE*8-1:0]   rd_data;
    logic                 wr_req;
    logic [7:0]           wr_addr;
    logic [WSIZE*8-1:0]   wr_data;
    logic [WSIZE-1:0]     wr_be;
    logic                 wr_gnt;
    logic                 ram_en;
    logic [WSIZE-1:0]     ram_we;
    logic [7:0]           ram_addr;
    logic [WSIZE*8-1:0]   ram_din;
    logic [WSIZE*8-1:0]   ram_dout;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, ram_dout,
        output rd_gnt, rd_valid, rd_data, wr_gnt, ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, ram_dout,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram256_arbiter.sv
// Shares the single-port 256-entry cache data RAM between CPU reads and SPI line-fill writes.
// Define RAM_ARB_RR_EN for round-robin contention; default is write-first with starvation override.
module ram256_arbiter #(
    parameter int WSIZE      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST,
    ram256_arbiter_if.slave    bus
);
    localparam int DW = WSIZE * 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic          rd_gnt_c;
    logic          wr_gnt_c;
    logic          rd_wins;
    logic          rd_valid_q;
    logic [DW-1:0] hold_q;
    logic [3:0]    starve_cnt;
`ifdef RAM_ARB_RR_EN
    logic          last_wr;
`endif

    always_comb begin
`ifdef RAM_ARB_RR_EN
        rd_wins = last_wr;
`else
        rd_wins = (starve_cnt == STARVE_LIM);
`endif
        rd_gnt_c = !RST && bus.rd_req && (!bus.wr_req || rd_wins);
        wr_gnt_c = !RST && bus.wr_req && !rd_gnt_c;
    end

    assign bus.rd_gnt   = rd_gnt_c;
    assign bus.wr_gnt   = wr_gnt_c;
    assign bus.ram_en   = rd_gnt_c || wr_gnt_c;
    assign bus.ram_we   = wr_gnt_c ? bus.wr_be : '0;
    assign bus.ram_addr = wr_gnt_c ? bus.wr_addr : (rd_gnt_c ? bus.rd_addr : 8'h00);
    assign bus.ram_din  = wr_gnt_c ? bus.wr_data : '0;

    // Reset in the cycle after a grant kills the in-flight read immediately.
    assign bus.rd_valid = rd_valid_q && !RST;
    assign bus.rd_data  = RST ? '0 : (rd_valid_q ? bus.ram_dout : hold_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_valid_q <= 1'b0;
            hold_q     <= '0;
            starve_cnt <= 4'd0;
`ifdef RAM_ARB_RR_EN
            last_wr    <= 1'b1;
`endif
        end else begin
            rd_valid_q <= rd_gnt_c;
            if (rd_valid_q)
                hold_q <= bus.ram_dout;
            if (!bus.rd_req || rd_gnt_c)
                starve_cnt <= 4'd0;
            else if (starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
`ifdef RAM_ARB_RR_EN
            if (bus.rd_req && bus.wr_req)
                last_wr <= wr_gnt_c;
`endif
        end
    end
endmodule
